// File: rtl/dmem_bank.sv
// dmem_bank: byte-addressed data memory for the load/store unit.
// Valid/ready request channel, one-cycle registered response, byte/half/word(/dword)
// accesses with sign or zero extension, error response for misaligned, out-of-range
// or illegal-size requests, and a full array clear after every reset.
module dmem_bank #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 512,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_unsigned,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_clr_busy
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RSP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    clr_cnt_q, clr_cnt_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   // Request decode signals
   logic [OFF_W-1:0]    req_off_s;
   logic [ADDR_W-1:0]   req_widx_full_s;
   logic [IDX_W-1:0]    req_widx_s;
   logic [3:0]          req_nbytes_s;
   logic                req_err_s;
   logic [DATA_W-1:0]   req_wdata_sh_s;
   logic [NB-1:0]       req_bmask_s;
   int                  off_i;
   int                  nb_i;

   // Handshake and array write port
   logic                req_ready_s;
   logic                accept_s;
   logic                rsp_hs_s;
   logic                mem_we_s;
   logic [IDX_W-1:0]    mem_widx_s;
   logic [DATA_W-1:0]   mem_wdata_s;
   logic [NB-1:0]       mem_bmask_s;

   // Select the addressed bytes of a word, move them to the LSBs and extend to DATA_W.
   function automatic logic [DATA_W-1:0] load_extend(
      input logic [DATA_W-1:0] word,
      input logic [OFF_W-1:0]  off,
      input logic [1:0]        size,
      input logic              uns
   );
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] res;
      logic              sign;
      int                wbits;
      sh = word >> {off, 3'b000};
      case (size)
         2'd0:    begin wbits = 8;      sign = sh[7];        end
         2'd1:    begin wbits = 16;     sign = sh[15];       end
         2'd2:    begin wbits = 32;     sign = sh[31];       end
         default: begin wbits = DATA_W; sign = sh[DATA_W-1]; end
      endcase
      for (int i = 0; i < DATA_W; i++) begin
         if (i < wbits) begin
            res[i] = sh[i];
         end else if (uns) begin
            res[i] = 1'b0;
         end else begin
            res[i] = sign;
         end
      end
      return res;
   endfunction

   // Decode the request: word index, byte offset, error conditions, store lanes and data.
   always_comb begin
      req_off_s       = i_req_addr[OFF_W-1:0];
      req_widx_full_s = i_req_addr >> OFF_W;
      req_widx_s      = req_widx_full_s[IDX_W-1:0];
      req_nbytes_s    = 4'd1 << i_req_size;
      req_err_s       = (32'(i_req_size) > 32'(OFF_W))
                      | ((4'(req_off_s) & (req_nbytes_s - 4'd1)) != 4'd0)
                      | (req_widx_full_s >= ADDR_W'(DEPTH));
      req_wdata_sh_s  = i_req_wdata << {req_off_s, 3'b000};
      off_i           = 32'(req_off_s);
      nb_i            = 32'(req_nbytes_s);
      for (int k = 0; k < NB; k++) begin
         if ((k >= off_i) && (k < off_i + nb_i)) begin
            req_bmask_s[k] = 1'b1;
         end else begin
            req_bmask_s[k] = 1'b0;
         end
      end
   end

   // Request-ready: open in IDLE, and in RSP only when the pending response drains this edge.
   always_comb begin
      case (state_q)
         ST_IDLE: req_ready_s = 1'b1;
         ST_RSP:  req_ready_s = i_rsp_ready;
         default: req_ready_s = 1'b0;
      endcase
   end

   assign accept_s = i_req_valid & req_ready_s & ~i_reset;
   assign rsp_hs_s = rsp_valid_q & i_rsp_ready;

   // Next-state, response and array-write control.
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      mem_we_s    = 1'b0;
      mem_widx_s  = req_widx_s;
      mem_wdata_s = req_wdata_sh_s;
      mem_bmask_s = req_bmask_s;
      case (state_q)
         ST_CLEAR: begin
            mem_we_s    = 1'b1;
            mem_widx_s  = clr_cnt_q;
            mem_wdata_s = {DATA_W{1'b0}};
            mem_bmask_s = {NB{1'b1}};
            clr_cnt_d   = clr_cnt_q + IDX_W'(1);
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CLEAR;
            end
         end
         ST_IDLE, ST_RSP: begin
            if (accept_s) begin
               state_d     = ST_RSP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = req_err_s;
               mem_we_s    = i_req_we & ~req_err_s;
               if (i_req_we | req_err_s) begin
                  rsp_rdata_d = {DATA_W{1'b0}};
               end else begin
                  rsp_rdata_d = load_extend(mem_q[req_widx_s], req_off_s,
                                            i_req_size, i_req_unsigned);
               end
            end else if (rsp_hs_s) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = {DATA_W{1'b0}};
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = {IDX_W{1'b0}};
         end
      endcase
   end

   // Control and response registers with synchronous reset into the clear sequence.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_CLEAR;
         clr_cnt_q   <= {IDX_W{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= {DATA_W{1'b0}};
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Data array: byte-lane masked write, used by both the clear sweep and stores.
   always_ff @(posedge i_clk) begin
      if (mem_we_s) begin
         for (int k = 0; k < NB; k++) begin
            if (mem_bmask_s[k]) begin
               mem_q[mem_widx_s][k*8 +: 8] <= mem_wdata_s[k*8 +: 8];
            end
         end
      end
   end

   assign o_req_ready = req_ready_s;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_clr_busy  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dmem_bank.sv
// Directed bench for dmem_bank (DEPTH=8, 32-bit words) with a response scoreboard.
module tb_dmem_bank;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [31:0] i_req_addr;
   logic [1:0]  i_req_size;
   logic        i_req_unsigned;
   logic [31:0] i_req_wdata;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic        o_clr_busy;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   dmem_bank #(.ADDR_W(32), .DEPTH(8), .DATA_W(32)) dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_req_we      (i_req_we),
      .i_req_addr    (i_req_addr),
      .i_req_size    (i_req_size),
      .i_req_unsigned(i_req_unsigned),
      .i_req_wdata   (i_req_wdata),
      .o_rsp_valid   (o_rsp_valid),
      .i_rsp_ready   (i_rsp_ready),
      .o_rsp_rdata   (o_rsp_rdata),
      .o_rsp_err     (o_rsp_err),
      .o_clr_busy    (o_clr_busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request, wait (bounded) for acceptance, record the expected response.
   task automatic req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
      int n;
      exp_t e;
      i_req_valid    = 1'b1;
      i_req_we       = we;
      i_req_addr     = addr;
      i_req_size     = size;
      i_req_unsigned = uns;
      i_req_wdata    = wdata;
      n = 0;
      while (o_req_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      check("req_ready", 32'(o_req_ready), 32'd1);
      if (o_req_ready === 1'b1) begin
         e.rdata = exp_rdata;
         e.err   = exp_err;
         sb_q.push_back(e);
         step();
      end
   endtask

   task automatic drop();
      i_req_valid = 1'b0;
   endtask

   // Count cycles with the request channel closed after reset (bounded).
   task automatic count_clear(input string tag);
      int cnt;
      cnt = 0;
      while (o_req_ready !== 1'b1 && cnt < 100) begin
         cnt++;
         step();
      end
      check(tag, 32'(cnt), 32'd8);
      check({tag, "_busy_done"}, 32'(o_clr_busy), 32'd0);
   endtask

   // Scoreboard: compare each response on the cycle it is consumed.
   always @(negedge clk) begin
      if (o_rsp_valid === 1'b1 && i_rsp_ready === 1'b1 && i_reset === 1'b0) begin
         if (sb_q.size() == 0) begin
            check("rsp_unexpected", 32'(o_rsp_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rsp_rdata", o_rsp_rdata, e.rdata);
            check("rsp_err", 32'(o_rsp_err), 32'(e.err));
         end
      end
   end

   initial begin
      i_reset        = 1'b1;
      i_req_valid    = 1'b0;
      i_req_we       = 1'b0;
      i_req_addr     = 32'd0;
      i_req_size     = 2'd0;
      i_req_unsigned = 1'b0;
      i_req_wdata    = 32'd0;
      i_rsp_ready    = 1'b1;

      // Reset state
      step();
      check("rst_req_ready", 32'(o_req_ready), 32'd0);
      check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("rst_rsp_rdata", o_rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(o_rsp_err), 32'd0);
      check("rst_clr_busy", 32'(o_clr_busy), 32'd1);
      i_reset = 1'b0;
      count_clear("clear_cycles");

      // Every word reads back zero, back-to-back, one response per cycle
      for (int i = 0; i < 8; i++) begin
         req(1'b0, 32'(i * 4), 2'd2, 1'b0, 32'd0, 32'd0, 1'b0);
         check("b2b_zero_valid", 32'(o_rsp_valid), 32'd1);
      end
      drop();
      step();

      // Byte store, signed and unsigned byte loads
      req(1'b1, 32'h5, 2'd0, 1'b0, 32'h0000_0080, 32'd0, 1'b0);
      req(1'b0, 32'h5, 2'd0, 1'b0, 32'd0, 32'hFFFF_FF80, 1'b0);
      req(1'b0, 32'h5, 2'd0, 1'b1, 32'd0, 32'h0000_0080, 1'b0);

      // Word store, half/byte loads, misaligned half
      req(1'b1, 32'h4, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0);
      req(1'b0, 32'h6, 2'd1, 1'b0, 32'd0, 32'hFFFF_DEAD, 1'b0);
      req(1'b0, 32'h3, 2'd1, 1'b0, 32'd0, 32'd0, 1'b1);
      req(1'b0, 32'h4, 2'd1, 1'b1, 32'd0, 32'h0000_BEEF, 1'b0);
      req(1'b0, 32'h7, 2'd0, 1'b1, 32'd0, 32'h0000_00DE, 1'b0);

      // Range errors, illegal size, array unchanged
      req(1'b1, 32'd32, 2'd2, 1'b0, 32'h1234_5678, 32'd0, 1'b1);
      req(1'b1, 32'h8000_0004, 2'd2, 1'b0, 32'h5555_AAAA, 32'd0, 1'b1);
      req(1'b0, 32'h0, 2'd3, 1'b0, 32'd0, 32'd0, 1'b1);
      req(1'b0, 32'h0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0);
      req(1'b0, 32'd28, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0);
      req(1'b0, 32'h4, 2'd2, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0);
      req(1'b1, 32'h8, 2'd2, 1'b0, 32'hCAFE_F00D, 32'd0, 1'b0);
      drop();
      step();

      // Response stall: outputs held, request channel closed
      i_rsp_ready = 1'b0;
      req(1'b0, 32'h8, 2'd2, 1'b0, 32'd0, 32'hCAFE_F00D, 1'b0);
      drop();
      for (int i = 0; i < 3; i++) begin
         check("stall_valid", 32'(o_rsp_valid), 32'd1);
         check("stall_rdata", o_rsp_rdata, 32'hCAFE_F00D);
         check("stall_err", 32'(o_rsp_err), 32'd0);
         check("stall_req_ready", 32'(o_req_ready), 32'd0);
         step();
      end
      i_rsp_ready = 1'b1;
      step();

      // Four back-to-back loads, responses in order on consecutive cycles
      req(1'b0, 32'h4, 2'd2, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0);
      check("b2b4_valid0", 32'(o_rsp_valid), 32'd1);
      req(1'b0, 32'h8, 2'd2, 1'b0, 32'd0, 32'hCAFE_F00D, 1'b0);
      check("b2b4_valid1", 32'(o_rsp_valid), 32'd1);
      req(1'b0, 32'h5, 2'd0, 1'b1, 32'd0, 32'h0000_00BE, 1'b0);
      check("b2b4_valid2", 32'(o_rsp_valid), 32'd1);
      req(1'b0, 32'h0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0);
      check("b2b4_valid3", 32'(o_rsp_valid), 32'd1);
      drop();
      step();

      // Reset while a response is pending
      req(1'b1, 32'd12, 2'd2, 1'b0, 32'h1111_1111, 32'd0, 1'b0);
      drop();
      step();
      i_rsp_ready = 1'b0;
      req(1'b0, 32'd12, 2'd2, 1'b0, 32'd0, 32'h1111_1111, 1'b0);
      drop();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      void'(sb_q.pop_back());
      check("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("mid_rst_clr_busy", 32'(o_clr_busy), 32'd1);
      check("mid_rst_req_ready", 32'(o_req_ready), 32'd0);
      count_clear("reclear_cycles");
      i_rsp_ready = 1'b1;
      req(1'b0, 32'd12, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0);
      req(1'b0, 32'd8, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0);
      req(1'b0, 32'd4, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0);
      drop();
      step();
      step();
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
